matrix_bram_arbiter: RTL and testbench
======================================

Name: matrix_bram_arbiter

Overview:
- Shares the single read/write port of the matrix-storage BRAM among NUM_REQ requesters: scanner, reader, computation engine and input writer.
- Replaces ad-hoc "mux on busy" address selection with round-robin arbitration, optional burst lock, and per-requester read-return tagging.
- Sits between the matrix_op_selector-level submodules and the BRAM primitive.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the default pointer start.
- ADDR_WIDTH, 14, BRAM word address width.
- DATA_WIDTH, 32, BRAM word width.
- READ_LATENCY, 1, BRAM read latency in cycles (1..3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request, held until granted.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_lock  in  NUM_REQ  keep ownership after the current grant (burst).
- gnt  out  NUM_REQ  one-hot combinational grant; an access is issued when req[i] and gnt[i] are both high.
- rvalid  out  NUM_REQ  one-hot; read data for requester i is on rdata.
- rdata  out  DATA_WIDTH  read data broadcast to all requesters.
- bram_en  out  1  BRAM enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data.
- busy  out  1  high while locked or while any read is in flight.

Behaviour:
- Reset values:
  - rr_ptr = 0, state = ARB_FREE, owner = 0.
  - Read pipeline valids all 0, so rvalid = 0 and busy = 0.
  - gnt, bram_en and bram_we are 0 while rst is high.
- State ARB_FREE:
  - Winner is the first set bit of req, searching from rr_ptr upward with wrap (NUM_REQ-1 wraps to 0).
  - gnt = onehot(winner) and bram_en = 1; bram_we, addr and wdata come from the winner's slices, all in the same cycle.
  - No req set: gnt = 0, bram_en = 0, and bram_addr/bram_wdata hold their last value.
  - On grant, rr_ptr <= winner+1 (mod NUM_REQ).
  - If req_lock[winner] is high at grant: owner <= winner and state <= ARB_LOCKED.
- State ARB_LOCKED:
  - Only owner can be granted; gnt = onehot(owner) when req[owner] is high, otherwise 0. rr_ptr is frozen.
  - Leaves to ARB_FREE at the end of any cycle in which req_lock[owner] is low; an access issued in that same cycle still completes.
  - A lock that stays high with req low keeps the port reserved; other requesters stall indefinitely. Requesters must drop lock at burst end.
- Read return:
  - Each issued read (we = 0) pushes {valid = 1, id = winner} into a READ_LATENCY-deep shift register.
  - rvalid[id] is asserted exactly READ_LATENCY cycles after issue, with rdata = bram_rdata that cycle.
  - Back-to-back reads from different requesters return in issue order, one per cycle.
  - Writes do not enter the pipeline and produce no rvalid.
- Simultaneous events:
  - Lock request and a competing req in the same cycle: the winner takes the lock; the loser sees gnt = 0 and retries.
  - Write followed by a read of the same address on the next cycle: read-first/write-first behaviour is the BRAM's; the arbiter does not reorder.
- Reset mid-operation:
  - The pipeline is cleared, so in-flight reads never produce rvalid.
  - A lock is dropped immediately.
- Widths: rr_ptr and owner are $clog2(NUM_REQ) bits; NUM_REQ = 1 is legal with a 1-bit pointer held at 0.

Decomposition:
- Package matrix_bram_arb_pkg:
  - arb_state_t enum {ARB_FREE, ARB_LOCKED}.
  - Constant MAX_READ_LATENCY = 3.
  - Requester index localparams REQ_SCANNER = 0, REQ_READER = 1, REQ_CALC = 2, REQ_WRITER = 3.
- Sub-module rr_priority_picker: purely combinational rotate-and-find-first. Inputs req and ptr; outputs winner index and any_valid. Reused by later arbiters.

Test Plan:
- Only req[1] high with addr 0x0005, read, READ_LATENCY 1 -> gnt = 0001_0b (bit 1) that cycle, bram_addr = 5; next cycle rvalid = 0010 with rdata = BRAM[5].
- req = 1111 held for 8 cycles, no lock -> grant order 0,1,2,3,0,1,2,3; rvalid ids follow the same order delayed by READ_LATENCY.
- Requester 1 bursts 4 reads (addr 10..13) with lock while req[2] is high -> gnt[2] = 0 until the cycle after lock drops; then requester 2 is granted; requester 1's data returns in order 10..13.
- Requester 3 write 0xDEADBEEF to addr 0x100, then requester 0 reads 0x100 -> bram_we pulses once; rvalid[0] with 0xDEADBEEF; no rvalid[3].
- rst asserted one cycle after a read is issued with READ_LATENCY 3 -> no rvalid ever appears; gnt = 0, busy = 0, rr_ptr = 0 after reset.
- READ_LATENCY = 2, alternating reads from requesters 0 and 2 every cycle -> continuous rvalid stream 0,2,0,2 starting 2 cycles after the first issue.

Source files
------------

// File: rtl/matrix_bram_arb_pkg.sv
// Shared types and constants for the matrix-storage BRAM port arbiter.
// Requester indices name the fixed wiring of the matrix_op_selector submodules.
package matrix_bram_arb_pkg;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_READ_LATENCY = 3;

  localparam int REQ_SCANNER = 0;
  localparam int REQ_READER  = 1;
  localparam int REQ_CALC    = 2;
  localparam int REQ_WRITER  = 3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, with wrap.
// Winner is 0 and any_valid is low when no request is set.
module rr_priority_picker
  import matrix_bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_valid
);

  // Scan from the farthest offset down so the closest match to ptr is the last write.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    winner    = '0;
    any_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      automatic int idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        winner    = PTR_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_bram_arbiter.sv
// Round-robin arbiter for the single matrix-storage BRAM port, with burst lock
// and a tagged read-return pipeline matching the BRAM read latency.
module matrix_bram_arbiter
  import matrix_bram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_wdata,
  input  logic [DATA_WIDTH-1:0]         bram_rdata,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t              state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        winner;
  logic                    any_valid;

  logic [PTR_W-1:0]        sel;
  logic                    sel_req;
  logic                    sel_we;
  logic                    sel_lock;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    issue;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [PTR_W-1:0]        pipe_id [READ_LATENCY];

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // While locked only the owner is eligible; otherwise the round-robin winner.
  always_comb begin
    sel       = (state == ARB_LOCKED) ? owner : winner;
    sel_req   = 1'b0;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == PTR_W'(i)) begin
        sel_req   = req[i];
        sel_we    = req_we[i];
        sel_lock  = req_lock[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    issue = !rst && sel_req && ((state == ARB_LOCKED) || any_valid);
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = issue && (sel == PTR_W'(i));
    end
  end

  // Address and write data hold their last issued value on idle cycles.
  assign bram_en    = issue;
  assign bram_we    = issue && sel_we;
  assign bram_addr  = issue ? sel_addr : addr_q;
  assign bram_wdata = issue ? sel_wdata : wdata_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= ARB_FREE;
      rr_ptr     <= '0;
      owner      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pipe_valid <= '0;
    end else begin
      if (issue) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end

      case (state)
        ARB_FREE: begin
          if (issue) begin
            rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
            if (sel_lock) begin
              owner <= winner;
              state <= ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          if (!sel_lock) state <= ARB_FREE;
        end
        default: state <= ARB_FREE;
      endcase

      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      pipe_valid[0] <= issue && !sel_we;
    end
  end

  // NOTE: the tag payload is not reset; it is only observed when its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pipe_id[i] <= pipe_id[i-1];
    end
    pipe_id[0] <= sel;
  end

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid[i] = pipe_valid[READ_LATENCY-1] && (pipe_id[READ_LATENCY-1] == PTR_W'(i));
    end
  end

  assign rdata = bram_rdata;
  assign busy  = (state == ARB_LOCKED) || (|pipe_valid);

endmodule

// File: tb/tb_matrix_bram_arbiter.sv
// Directed bench: three arbiters (read latency 1, 2, 3) share one stimulus, each
// with its own BRAM model whose initial contents are A000_0000 | address.
module tb_matrix_bram_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [55:0]  req_addr;
  logic [3:0]   req_we;
  logic [127:0] req_wdata;
  logic [3:0]   req_lock;

  logic [3:0]   gnt_a        [3];
  logic [3:0]   rvalid_a     [3];
  logic [31:0]  rdata_a      [3];
  logic         bram_en_a    [3];
  logic         bram_we_a    [3];
  logic [13:0]  bram_addr_a  [3];
  logic [31:0]  bram_wdata_a [3];
  logic [31:0]  bram_rdata_a [3];
  logic         busy_a       [3];

  int checks;
  int failures;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return 32'hA000_0000 | 32'(a);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g + 1;
    logic [31:0] mem   [1024];
    logic [31:0] rpipe [LAT];

    initial for (int a = 0; a < 1024; a++) mem[a] <= init_word(a);

    // Read-first BRAM model with LAT cycles of read latency.
    always @(posedge clk) begin
      if (bram_en_a[g]) begin
        rpipe[0] <= mem[bram_addr_a[g][9:0]];
        if (bram_we_a[g]) mem[bram_addr_a[g][9:0]] <= bram_wdata_a[g];
      end
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bram_rdata_a[g] = rpipe[LAT-1];

    matrix_bram_arbiter #(
      .NUM_REQ(4), .ADDR_WIDTH(14), .DATA_WIDTH(32), .READ_LATENCY(LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_addr   (req_addr),
      .req_we     (req_we),
      .req_wdata  (req_wdata),
      .req_lock   (req_lock),
      .gnt        (gnt_a[g]),
      .rvalid     (rvalid_a[g]),
      .rdata      (rdata_a[g]),
      .bram_en    (bram_en_a[g]),
      .bram_we    (bram_we_a[g]),
      .bram_addr  (bram_addr_a[g]),
      .bram_wdata (bram_wdata_a[g]),
      .bram_rdata (bram_rdata_a[g]),
      .busy       (busy_a[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_all();
    req      = '0;
    req_we   = '0;
    req_lock = '0;
  endtask

  task automatic drive(input int i, input logic [13:0] a, input logic we,
                       input logic [31:0] d, input logic lk);
    req[i]               = 1'b1;
    req_addr[i*14 +: 14] = a;
    req_we[i]            = we;
    req_wdata[i*32 +: 32] = d;
    req_lock[i]          = lk;
  endtask

  task automatic do_reset();
    clear_all();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    req = 4'hF;
    rst = 1'b1;
    cyc();
    smp();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (gnt_a[g] !== 4'b0000) begin
        failures++; $display("FAIL reset_gnt[%0d] got=%b exp=0000", g, gnt_a[g]);
      end
      checks++;
      if (bram_en_a[g] !== 1'b0 || bram_we_a[g] !== 1'b0) begin
        failures++; $display("FAIL reset_en_we[%0d] got=%b%b exp=00", g, bram_en_a[g], bram_we_a[g]);
      end
      checks++;
      if (rvalid_a[g] !== 4'b0000 || busy_a[g] !== 1'b0) begin
        failures++; $display("FAIL reset_rvalid_busy[%0d] got=%b/%b exp=0000/0", g, rvalid_a[g], busy_a[g]);
      end
    end
    cyc();
    rst = 1'b0;
    clear_all();
  endtask

  task automatic test_single_read();
    do_reset();
    drive(1, 14'h0005, 1'b0, 32'h0, 1'b0);
    smp();
    checks++;
    if (gnt_a[0] !== 4'b0010) begin
      failures++; $display("FAIL single_gnt got=%b exp=0010", gnt_a[0]);
    end
    checks++;
    if (bram_addr_a[0] !== 14'h0005 || bram_en_a[0] !== 1'b1 || bram_we_a[0] !== 1'b0) begin
      failures++; $display("FAIL single_bram got=%h/%b/%b exp=0005/1/0", bram_addr_a[0], bram_en_a[0], bram_we_a[0]);
    end
    cyc();
    clear_all();
    smp();
    checks++;
    if (rvalid_a[0] !== 4'b0010) begin
      failures++; $display("FAIL single_rvalid got=%b exp=0010", rvalid_a[0]);
    end
    checks++;
    if (rdata_a[0] !== init_word(5)) begin
      failures++; $display("FAIL single_rdata got=%h exp=%h", rdata_a[0], init_word(5));
    end
    checks++;
    if (bram_en_a[0] !== 1'b0 || bram_addr_a[0] !== 14'h0005) begin
      failures++; $display("FAIL single_idle_hold got=%b/%h exp=0/0005", bram_en_a[0], bram_addr_a[0]);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 14'(14'h20 + i), 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (k == 8) clear_all();
      smp();
      if (k < 8) begin
        exp = 4'(1 << (k % 4));
        checks++;
        if (gnt_a[0] !== exp) begin
          failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt_a[0], exp);
        end
      end
      if (k >= 1) begin
        exp = 4'(1 << ((k - 1) % 4));
        checks++;
        if (rvalid_a[0] !== exp || rdata_a[0] !== init_word(32 + (k - 1) % 4)) begin
          failures++; $display("FAIL rr_rvalid k=%0d got=%b/%h exp=%b/%h", k, rvalid_a[0], rdata_a[0],
                               exp, init_word(32 + (k - 1) % 4));
        end
      end else begin
        checks++;
        if (rvalid_a[0] !== 4'b0000) begin
          failures++; $display("FAIL rr_rvalid_first got=%b exp=0000", rvalid_a[0]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_lock_burst();
    logic [3:0] exp;
    do_reset();
    drive(2, 14'h0030, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        drive(1, 14'(10 + k), 1'b0, 32'h0, k < 3);
      end else begin
        req[1]      = 1'b0;
        req_lock[1] = 1'b0;
      end
      if (k == 5) req[2] = 1'b0;
      smp();
      exp = (k < 4) ? 4'b0010 : (k == 4) ? 4'b0100 : 4'b0000;
      checks++;
      if (gnt_a[0] !== exp) begin
        failures++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, gnt_a[0], exp);
      end
      if (k < 4) begin
        checks++;
        if (bram_addr_a[0] !== 14'(10 + k)) begin
          failures++; $display("FAIL lock_addr k=%0d got=%h exp=%h", k, bram_addr_a[0], 14'(10 + k));
        end
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (rvalid_a[0] !== 4'b0010 || rdata_a[0] !== init_word(10 + k - 1)) begin
          failures++; $display("FAIL lock_rdata k=%0d got=%b/%h exp=0010/%h", k, rvalid_a[0], rdata_a[0],
                               init_word(10 + k - 1));
        end
      end
      if (k == 5) begin
        checks++;
        if (rvalid_a[0] !== 4'b0100 || rdata_a[0] !== init_word(48)) begin
          failures++; $display("FAIL lock_loser_rdata got=%b/%h exp=0100/%h", rvalid_a[0], rdata_a[0], init_word(48));
        end
      end
      if (k == 1) begin
        checks++;
        if (busy_a[0] !== 1'b1) begin
          failures++; $display("FAIL lock_busy got=%b exp=1", busy_a[0]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    drive(3, 14'h0100, 1'b1, 32'hDEADBEEF, 1'b0);
    smp();
    checks++;
    if (gnt_a[0] !== 4'b1000 || bram_we_a[0] !== 1'b1) begin
      failures++; $display("FAIL wr_gnt_we got=%b/%b exp=1000/1", gnt_a[0], bram_we_a[0]);
    end
    checks++;
    if (bram_addr_a[0] !== 14'h0100 || bram_wdata_a[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_bus got=%h/%h exp=0100/deadbeef", bram_addr_a[0], bram_wdata_a[0]);
    end
    cyc();
    clear_all();
    drive(0, 14'h0100, 1'b0, 32'h0, 1'b0);
    smp();
    checks++;
    if (gnt_a[0] !== 4'b0001 || bram_we_a[0] !== 1'b0 || rvalid_a[0] !== 4'b0000) begin
      failures++; $display("FAIL rd_issue got=%b/%b/%b exp=0001/0/0000", gnt_a[0], bram_we_a[0], rvalid_a[0]);
    end
    cyc();
    clear_all();
    smp();
    checks++;
    if (rvalid_a[0] !== 4'b0001 || rdata_a[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_return got=%b/%h exp=0001/deadbeef", rvalid_a[0], rdata_a[0]);
    end
    checks++;
    if (bram_en_a[0] !== 1'b0 || bram_we_a[0] !== 1'b0) begin
      failures++; $display("FAIL wr_single_pulse got=%b/%b exp=0/0", bram_en_a[0], bram_we_a[0]);
    end
    cyc();
    smp();
    checks++;
    if (rvalid_a[0] !== 4'b0000) begin
      failures++; $display("FAIL wr_no_rvalid got=%b exp=0000", rvalid_a[0]);
    end
    cyc();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(0, 14'h0040, 1'b0, 32'h0, 1'b0);
    smp();
    checks++;
    if (gnt_a[2] !== 4'b0001) begin
      failures++; $display("FAIL mid_issue got=%b exp=0001", gnt_a[2]);
    end
    cyc();
    clear_all();
    drive(1, 14'h0041, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    smp();
    checks++;
    if (gnt_a[2] !== 4'b0000 || bram_en_a[2] !== 1'b0) begin
      failures++; $display("FAIL mid_gnt_in_reset got=%b/%b exp=0000/0", gnt_a[2], bram_en_a[2]);
    end
    cyc();
    rst = 1'b0;
    clear_all();
    for (int k = 0; k < 5; k++) begin
      smp();
      checks++;
      if (rvalid_a[2] !== 4'b0000 || busy_a[2] !== 1'b0) begin
        failures++; $display("FAIL mid_flush k=%0d got=%b/%b exp=0000/0", k, rvalid_a[2], busy_a[2]);
      end
      cyc();
    end
    for (int i = 0; i < 4; i++) drive(i, 14'(14'h60 + i), 1'b0, 32'h0, 1'b0);
    smp();
    checks++;
    if (gnt_a[2] !== 4'b0001) begin
      failures++; $display("FAIL mid_ptr_reset got=%b exp=0001", gnt_a[2]);
    end
    cyc();
    clear_all();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      clear_all();
      if (k < 6) drive((k % 2 == 1) ? 2 : 0, 14'(14'h50 + k), 1'b0, 32'h0, 1'b0);
      smp();
      if (k < 6) begin
        exp = (k % 2 == 1) ? 4'b0100 : 4'b0001;
        checks++;
        if (gnt_a[1] !== exp) begin
          failures++; $display("FAIL b2b_gnt k=%0d got=%b exp=%b", k, gnt_a[1], exp);
        end
      end
      if (k >= 2) begin
        exp = ((k - 2) % 2 == 1) ? 4'b0100 : 4'b0001;
        checks++;
        if (rvalid_a[1] !== exp || rdata_a[1] !== init_word(80 + k - 2)) begin
          failures++; $display("FAIL b2b_rvalid k=%0d got=%b/%h exp=%b/%h", k, rvalid_a[1], rdata_a[1],
                               exp, init_word(80 + k - 2));
        end
      end else begin
        checks++;
        if (rvalid_a[1] !== 4'b0000) begin
          failures++; $display("FAIL b2b_early k=%0d got=%b exp=0000", k, rvalid_a[1]);
        end
      end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    clear_all();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_write_read();
    test_reset_midflight();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
